mem_port_arb: RTL and testbench
===============================

// Module: mem_port_arb
// PURPOSE
// Shares the single cache-to-memory port (req/rdy/valid, burst len) between NUM_REQ cache
// controllers, e.g. I-side and D-side. Round-robin with whole-transaction lock.
// Sits between the controllers' o_mem_* outputs and the memory/AXI bridge, and returns
// read beats and completion to the owning requester only.
// PARAMETERS
// NUM_REQ          2   number of requesters (2..4)
// ADDR_WIDTH      10   byte address width
// DATA_WIDTH      32   data beat width
// DATA_SIZE_BYTES  4   byte enables per beat
// LEN_WIDTH        8   burst length field; beats = len+1
// PORTS
// clk          in   1                  clock, rising edge
// reset_n      in   1                  asynchronous reset, active low
// i_req        in   NUM_REQ            per-requester request; held until its o_rdy
// i_addr       in   NUM_REQ*ADDR_WIDTH per-requester address, word aligned
// i_wen        in   NUM_REQ            1 = write, 0 = read burst
// i_ben        in   NUM_REQ*DSB        write byte enables
// i_len        in   NUM_REQ*LEN_WIDTH  read burst len; must be 0 for writes
// i_data       in   NUM_REQ*DATA_WIDTH write data
// o_rdy        out  NUM_REQ            one-cycle completion pulse to owner
// o_valid      out  NUM_REQ            read beat valid, owner only
// o_data       out  DATA_WIDTH         read beat data, shared bus
// o_mem_req    out  1                  request to memory
// o_mem_addr   out  ADDR_WIDTH         latched addr of winner
// o_mem_wen    out  1                  latched wen
// o_mem_ben    out  DATA_SIZE_BYTES    latched ben
// o_mem_len    out  LEN_WIDTH          latched len
// o_mem_data   out  DATA_WIDTH         latched write data
// i_mem_rdy    in   1                  memory accepts request in the same cycle as o_mem_req
// i_mem_valid  in   1                  read beat valid
// i_mem_data   in   DATA_WIDTH         read beat data
// o_owner      out  NUM_REQ            one-hot current grant, 0 when idle
// o_err        out  1                  sticky protocol error
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; rr pointer selects requester 0 first; beat_cnt 0.
// - FSM IDLE -> ISSUE -> (READ) -> DONE -> IDLE.
// - IDLE: if any i_req, winner = first set bit at or after ptr, wrapping. Register the
//   winner's addr/wen/ben/len/data and o_owner, then go to ISSUE.
// - Latency: i_req at cycle N gives o_mem_req=1 at N+1.
// - ISSUE: hold o_mem_req and all o_mem_* stable until i_mem_rdy=1.
//   - On acceptance of a write, go to DONE.
//   - On acceptance of a read, go to READ with beat_cnt=0.
// - READ: each i_mem_valid gives o_valid[owner]=1 and o_data=i_mem_data in the same cycle
//   (combinational), then beat_cnt++. The beat where beat_cnt==len goes to DONE.
// - DONE: o_rdy[owner]=1 for exactly one cycle (registered); ptr = owner+1 mod NUM_REQ;
//   o_owner cleared; next state IDLE. i_req is not sampled in DONE.
// - A requester re-requesting right after o_rdy competes in the next IDLE cycle.
// - o_mem_req is 0 in IDLE, READ and DONE. Exactly one o_rdy in flight ever.
// - Simultaneous requests: only the winner proceeds; the loser's i_req stays high and is
//   served next. No starvation: worst-case wait is NUM_REQ-1 transactions.
// - beat_cnt is LEN_WIDTH+1 bits wide, so len=255 (256 beats) does not wrap.
// - o_err is set (sticky until reset) on any of:
//   - i_mem_valid outside READ;
//   - the winner has wen=1 and len!=0; the transaction still proceeds as a single write;
//   - i_mem_rdy while o_mem_req=0.
// - Reset mid-transaction: immediate return to IDLE, outputs 0. Late beats from the aborted
//   burst then raise o_err; this is expected and must be handled by the system reset.
// STRUCTURE
// - Shared package memArbPkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_READ, ARB_DONE} arb_state_t
//   - MEM_LEN_WIDTH = 8
//   - max NUM_REQ = 4
// - One sub-module rr_pick: combinational round-robin picker; (req vec, ptr) -> one-hot
//   grant plus index. Formally checked for onehot0 in the props package.
// - Bind a props module using the existing REQ_PROP/RDY_PROP/VALID_PROP macros on each
//   requester port and on the memory port.
// TESTING
// 1 Single read: req0 at addr 0x040, len=3; mem rdy after 2 cycles, 4 beats 0xA0..0xA3
//   -> o_valid[0] x4 with matching data, o_rdy[0] one cycle after last beat, o_valid[1]=0.
// 2 Simultaneous after reset: req0 wr 0x100 and req1 rd 0x200 -> req0 wins first.
//   Then req1; the following tie goes to req0 again (ptr alternates).
// 3 Back-to-back: req1 held continuously, 3 writes -> grants 1,1,1, each separated by the
//   IDLE cycle. Never two o_rdy pulses in adjacent cycles.
// 4 Max burst: len=255 read -> exactly 256 o_valid beats, completion on the 256th, no wrap.
// 5 Errors: i_mem_valid in IDLE -> o_err=1 and held; write with len=2 -> o_err=1, single write.
// 6 reset_n low mid-READ (after beat 1 of 4) -> outputs 0 asynchronously. After release a
//   new req0 is served normally; stray beats set o_err.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the cache-to-memory port arbiter.
package memArbPkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_READ, ARB_DONE} arb_state_t;

  localparam int MEM_LEN_WIDTH = 8;
  localparam int MAX_NUM_REQ   = 4;
  localparam int PTR_WIDTH     = 2;

  // Round-robin pointer advance; wraps at the configured requester count.
  function automatic logic [PTR_WIDTH-1:0] nextPtr(input logic [PTR_WIDTH-1:0] ptr,
                                                   input int numReq);
    return (int'(ptr) == numReq - 1) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/mem_port_arb_rr_pick.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module rr_pick
  import memArbPkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [PTR_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [PTR_WIDTH-1:0] o_idx
);

  int   w_pos;
  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos = (int'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = PTR_WIDTH'(w_pos);
      end
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing one memory port between cache controllers, with the
// grant locked for a whole transaction and read beats routed to the owner only.
module mem_port_arb
  import memArbPkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_SIZE_BYTES = 4,
  parameter int LEN_WIDTH       = MEM_LEN_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_REQ-1:0]                   i_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]        i_addr,
  input  logic [NUM_REQ-1:0]                   i_wen,
  input  logic [NUM_REQ*DATA_SIZE_BYTES-1:0]   i_ben,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]         i_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]        i_data,
  output logic [NUM_REQ-1:0]                   o_rdy,
  output logic [NUM_REQ-1:0]                   o_valid,
  output logic [DATA_WIDTH-1:0]                o_data,
  output logic                                 o_mem_req,
  output logic [ADDR_WIDTH-1:0]                o_mem_addr,
  output logic                                 o_mem_wen,
  output logic [DATA_SIZE_BYTES-1:0]           o_mem_ben,
  output logic [LEN_WIDTH-1:0]                 o_mem_len,
  output logic [DATA_WIDTH-1:0]                o_mem_data,
  input  logic                                 i_mem_rdy,
  input  logic                                 i_mem_valid,
  input  logic [DATA_WIDTH-1:0]                i_mem_data,
  output logic [NUM_REQ-1:0]                   o_owner,
  output logic                                 o_err
);

  arb_state_t                 r_state;
  logic [NUM_REQ-1:0]         r_owner;
  logic [NUM_REQ-1:0]         r_rdy;
  logic [PTR_WIDTH-1:0]       r_ptr;
  logic [PTR_WIDTH-1:0]       r_ownerIdx;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic                       r_wen;
  logic [DATA_SIZE_BYTES-1:0] r_ben;
  logic [LEN_WIDTH-1:0]       r_len;
  logic [DATA_WIDTH-1:0]      r_data;
  logic [LEN_WIDTH:0]         r_beatCnt;
  logic                       r_err;

  logic [NUM_REQ-1:0]         w_grant;
  logic [PTR_WIDTH-1:0]       w_idx;
  logic [ADDR_WIDTH-1:0]      w_selAddr;
  logic                       w_selWen;
  logic [DATA_SIZE_BYTES-1:0] w_selBen;
  logic [LEN_WIDTH-1:0]       w_selLen;
  logic [DATA_WIDTH-1:0]      w_selData;
  logic                       w_beat;
  logic                       w_lastBeat;
  logic                       w_errEvt;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req  (i_req),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );

  always_comb begin
    w_selAddr = '0;
    w_selWen  = 1'b0;
    w_selBen  = '0;
    w_selLen  = '0;
    w_selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_selAddr = i_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_selWen  = i_wen[i];
        w_selBen  = i_ben[i*DATA_SIZE_BYTES +: DATA_SIZE_BYTES];
        w_selLen  = i_len[i*LEN_WIDTH +: LEN_WIDTH];
        w_selData = i_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_beat     = (r_state == ARB_READ) && i_mem_valid;
  assign w_lastBeat = (r_beatCnt == {1'b0, r_len});

  // Protocol violations: stray beats, multi-beat writes, and memory accepting nothing.
  assign w_errEvt = (i_mem_valid && (r_state != ARB_READ)) ||
                    ((r_state == ARB_IDLE) && (|i_req) && w_selWen && (w_selLen != '0)) ||
                    (i_mem_rdy && (r_state != ARB_ISSUE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_owner    <= '0;
      r_rdy      <= '0;
      r_ptr      <= '0;
      r_ownerIdx <= '0;
      r_addr     <= '0;
      r_wen      <= 1'b0;
      r_ben      <= '0;
      r_len      <= '0;
      r_data     <= '0;
      r_beatCnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rdy <= '0;
      if (w_errEvt) r_err <= 1'b1;
      case (r_state)
        ARB_IDLE: begin
          if (|i_req) begin
            r_owner    <= w_grant;
            r_ownerIdx <= w_idx;
            r_addr     <= w_selAddr;
            r_wen      <= w_selWen;
            r_ben      <= w_selBen;
            // A write is always issued as a single beat, whatever len the requester gave.
            r_len      <= w_selWen ? '0 : w_selLen;
            r_data     <= w_selData;
            r_state    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (i_mem_rdy) begin
            r_beatCnt <= '0;
            if (r_wen) begin
              r_state <= ARB_DONE;
              r_rdy   <= r_owner;
            end else begin
              r_state <= ARB_READ;
            end
          end
        end
        ARB_READ: begin
          if (i_mem_valid) begin
            r_beatCnt <= r_beatCnt + (LEN_WIDTH+1)'(1);
            if (w_lastBeat) begin
              r_state <= ARB_DONE;
              r_rdy   <= r_owner;
            end
          end
        end
        ARB_DONE: begin
          r_ptr   <= nextPtr(r_ownerIdx, NUM_REQ);
          r_owner <= '0;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_mem_req  = (r_state == ARB_ISSUE);
  assign o_mem_addr = r_addr;
  assign o_mem_wen  = r_wen;
  assign o_mem_ben  = r_ben;
  assign o_mem_len  = r_len;
  assign o_mem_data = r_data;
  assign o_valid    = w_beat ? r_owner : '0;
  assign o_data     = w_beat ? i_mem_data : '0;
  assign o_rdy      = r_rdy;
  assign o_owner    = r_owner;
  assign o_err      = r_err;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: a cycle table for a single read plus hand-written
// sequences for arbitration order, back-to-back grants, max burst, errors and reset.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req, wen;
  logic [9:0]  addr0, addr1;
  logic [3:0]  ben0, ben1;
  logic [7:0]  len0, len1;
  logic [31:0] wdata0, wdata1;
  logic        memRdy, memValid;
  logic [31:0] memData;

  logic [1:0]  rdy, valid, owner;
  logic [31:0] data, memWdata;
  logic        memReq, memWen, err;
  logic [9:0]  memAddr;
  logic [3:0]  memBen;
  logic [7:0]  memLen;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  req;
    logic        memRdy;
    logic        memValid;
    logic [31:0] memData;
    logic        expMemReq;
    logic [1:0]  expOwner;
    logic [1:0]  expRdy;
    logic [1:0]  expValid;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[12];

  mem_port_arb dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (req),
    .i_addr     ({addr1, addr0}),
    .i_wen      (wen),
    .i_ben      ({ben1, ben0}),
    .i_len      ({len1, len0}),
    .i_data     ({wdata1, wdata0}),
    .o_rdy      (rdy),
    .o_valid    (valid),
    .o_data     (data),
    .o_mem_req  (memReq),
    .o_mem_addr (memAddr),
    .o_mem_wen  (memWen),
    .o_mem_ben  (memBen),
    .o_mem_len  (memLen),
    .o_mem_data (memWdata),
    .i_mem_rdy  (memRdy),
    .i_mem_valid(memValid),
    .i_mem_data (memData),
    .o_owner    (owner),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    req      = v.req;
    memRdy   = v.memRdy;
    memValid = v.memValid;
    memData  = v.memData;
  endtask

  task automatic resetDut();
    reset_n  = 1'b0;
    req = '0; wen = '0; len0 = '0; len1 = '0;
    addr0 = '0; addr1 = '0; ben0 = 4'hF; ben1 = 4'hF;
    wdata0 = '0; wdata1 = '0;
    memRdy = 1'b0; memValid = 1'b0; memData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  // Completion pulses must be single, one-hot and never in adjacent cycles.
  logic [1:0] prevRdy = '0;
  always @(negedge clk) begin
    if (rdy != 2'b00) begin
      checks++;
      if (prevRdy != 2'b00 || $countones(rdy) != 1) begin
        errors++;
        $display("[TB] FAIL rdy pulse: got %b previous %b expected single isolated pulse",
                 rdy, prevRdy);
      end
    end
    prevRdy = rdy;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats;
    int earlyRdy;

    vecs[0]  = '{2'b01, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 2'b00, 2'b00, 32'h0};
    vecs[1]  = '{2'b01, 1'b0, 1'b0, 32'h0,  1'b1, 2'b01, 2'b00, 2'b00, 32'h0};
    vecs[2]  = '{2'b01, 1'b0, 1'b0, 32'h0,  1'b1, 2'b01, 2'b00, 2'b00, 32'h0};
    vecs[3]  = '{2'b01, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 2'b00, 2'b00, 32'h0};
    vecs[4]  = '{2'b01, 1'b0, 1'b1, 32'hA0, 1'b0, 2'b01, 2'b00, 2'b01, 32'hA0};
    vecs[5]  = '{2'b01, 1'b0, 1'b1, 32'hA1, 1'b0, 2'b01, 2'b00, 2'b01, 32'hA1};
    vecs[6]  = '{2'b01, 1'b0, 1'b0, 32'h0,  1'b0, 2'b01, 2'b00, 2'b00, 32'h0};
    vecs[7]  = '{2'b01, 1'b0, 1'b1, 32'hA2, 1'b0, 2'b01, 2'b00, 2'b01, 32'hA2};
    vecs[8]  = '{2'b01, 1'b0, 1'b1, 32'hA3, 1'b0, 2'b01, 2'b00, 2'b01, 32'hA3};
    vecs[9]  = '{2'b01, 1'b0, 1'b0, 32'h0,  1'b0, 2'b01, 2'b01, 2'b00, 32'h0};
    vecs[10] = '{2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 2'b00, 2'b00, 32'h0};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 2'b00, 2'b00, 32'h0};

    reset_n = 1'b0;
    req = '0; wen = '0; memRdy = 1'b0; memValid = 1'b0; memData = '0;
    #1;
    checkOutput("reset outputs",
                {rdy, valid, data, memReq, memAddr, memWen, memBen, memLen, memWdata, owner, err},
                128'h0);

    // Single read of four beats with a two-cycle memory stall.
    resetDut();
    addr0 = 10'h040; len0 = 8'd3; wen = 2'b00;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(vecs[k]);
      @(negedge clk);
      checkOutput($sformatf("t1 cycle %0d", k), {memReq, owner, rdy, valid, data, err},
                  {vecs[k].expMemReq, vecs[k].expOwner, vecs[k].expRdy, vecs[k].expValid,
                   vecs[k].expData, 1'b0});
      if (vecs[k].expMemReq)
        checkOutput("t1 mem addr/len/wen", {memAddr, memLen, memWen}, {10'h040, 8'd3, 1'b0});
      tick();
    end

    // Simultaneous requests: req0 first, then req1, then the tie returns to req0.
    resetDut();
    addr0 = 10'h100; wen = 2'b01; wdata0 = 32'hDEAD_0001; ben0 = 4'h5;
    addr1 = 10'h200; len1 = 8'd0; req = 2'b11;
    @(negedge clk); checkOutput("t2 idle owner", {owner, memReq}, {2'b00, 1'b0});
    tick();
    @(negedge clk); checkOutput("t2 first winner", owner, 2'b01);
    checkOutput("t2 write latch", {memAddr, memWen, memWdata, memBen},
                {10'h100, 1'b1, 32'hDEAD_0001, 4'h5});
    memRdy = 1'b1; tick(); memRdy = 1'b0;
    @(negedge clk); checkOutput("t2 rdy req0", rdy, 2'b01);
    tick(); req = 2'b10;
    @(negedge clk); checkOutput("t2 idle gap", {owner, memReq}, {2'b00, 1'b0});
    tick();
    @(negedge clk); checkOutput("t2 second winner", {owner, memAddr, memWen}, {2'b10, 10'h200, 1'b0});
    memRdy = 1'b1; tick(); memRdy = 1'b0; memValid = 1'b1; memData = 32'h55;
    @(negedge clk); checkOutput("t2 beat req1", {valid, data}, {2'b10, 32'h55});
    tick(); memValid = 1'b0;
    @(negedge clk); checkOutput("t2 rdy req1", rdy, 2'b10);
    tick(); req = 2'b11;
    tick();
    @(negedge clk); checkOutput("t2 tie to req0", owner, 2'b01);
    memRdy = 1'b1; tick(); memRdy = 1'b0;
    @(negedge clk); checkOutput("t2 rdy req0 again", {rdy, err}, {2'b01, 1'b0});
    tick(); req = 2'b00;

    // Back-to-back writes from req1 held continuously.
    resetDut();
    wen = 2'b10; addr1 = 10'h300; req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); checkOutput($sformatf("t3 idle gap %0d", i), {owner, memReq}, {2'b00, 1'b0});
      tick();
      @(negedge clk); checkOutput($sformatf("t3 grant %0d", i), {owner, memReq}, {2'b10, 1'b1});
      memRdy = 1'b1; tick(); memRdy = 1'b0;
      @(negedge clk); checkOutput($sformatf("t3 rdy %0d", i), rdy, 2'b10);
      tick();
    end
    req = 2'b00;

    // Maximum burst: 256 beats, completion only after the last.
    resetDut();
    wen = 2'b00; addr0 = 10'h010; len0 = 8'd255; req = 2'b01;
    tick();
    @(negedge clk); checkOutput("t4 issue", {memReq, memLen}, {1'b1, 8'd255});
    memRdy = 1'b1; tick(); memRdy = 1'b0;
    beats = 0; earlyRdy = 0;
    for (int b = 0; b < 256; b++) begin
      memValid = 1'b1; memData = 32'hB000_0000 + 32'(b);
      @(negedge clk);
      if (valid == 2'b01 && data == memData) beats++;
      if (rdy != 2'b00) earlyRdy++;
      tick();
    end
    memValid = 1'b0;
    checkOutput("t4 beat count", 128'(beats), 128'd256);
    checkOutput("t4 early rdy", 128'(earlyRdy), 128'd0);
    @(negedge clk); checkOutput("t4 completion", {rdy, err}, {2'b01, 1'b0});
    tick(); req = 2'b00;
    @(negedge clk); checkOutput("t4 back to idle", {rdy, owner}, {2'b00, 2'b00});
    tick();

    // Errors: stray beat in IDLE, then a write carrying a nonzero len.
    resetDut();
    @(negedge clk); checkOutput("t5 err clear", err, 1'b0);
    memValid = 1'b1; tick(); memValid = 1'b0;
    @(negedge clk); checkOutput("t5 stray beat err", err, 1'b1);
    repeat (3) tick();
    @(negedge clk); checkOutput("t5 err sticky", err, 1'b1);
    resetDut();
    wen = 2'b01; len0 = 8'd2; addr0 = 10'h020; req = 2'b01;
    @(negedge clk); checkOutput("t5 err before write", err, 1'b0);
    tick();
    @(negedge clk); checkOutput("t5 write len err", err, 1'b1);
    checkOutput("t5 single write", {memWen, memLen, memReq}, {1'b1, 8'd0, 1'b1});
    memRdy = 1'b1; tick(); memRdy = 1'b0;
    @(negedge clk); checkOutput("t5 write done", {rdy, valid}, {2'b01, 2'b00});
    tick(); req = 2'b00;

    // Reset in the middle of a read burst, then stray beat and a clean transaction.
    resetDut();
    wen = 2'b00; len0 = 8'd3; addr0 = 10'h080; req = 2'b01;
    tick();
    memRdy = 1'b1; tick(); memRdy = 1'b0;
    memValid = 1'b1; memData = 32'hC0;
    @(negedge clk); checkOutput("t6 beat0", {valid, data}, {2'b01, 32'hC0});
    tick(); memData = 32'hC1;
    @(negedge clk); checkOutput("t6 beat1", {valid, data}, {2'b01, 32'hC1});
    tick(); memData = 32'hC2;
    #2 reset_n = 1'b0;
    #1 checkOutput("t6 async reset", {valid, data, owner, memReq, rdy, err}, 128'h0);
    memValid = 1'b0; req = 2'b00;
    @(negedge clk); @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    tick();
    memValid = 1'b1; memData = 32'hC3; tick(); memValid = 1'b0;
    @(negedge clk); checkOutput("t6 stray beat err", err, 1'b1);
    len0 = 8'd1; req = 2'b01;
    tick();
    @(negedge clk); checkOutput("t6 new grant", {owner, memReq, memAddr}, {2'b01, 1'b1, 10'h080});
    memRdy = 1'b1; tick(); memRdy = 1'b0;
    memValid = 1'b1; memData = 32'hD0;
    @(negedge clk); checkOutput("t6 new beat0", {valid, data}, {2'b01, 32'hD0});
    tick(); memData = 32'hD1;
    @(negedge clk); checkOutput("t6 new beat1", {valid, data}, {2'b01, 32'hD1});
    tick(); memValid = 1'b0;
    @(negedge clk); checkOutput("t6 new rdy", rdy, 2'b01);
    tick(); req = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
